zigbee_chip_spreader: RTL and testbench



---
 rtl/zigbee_pkg.sv | 27 ++
 rtl/zigbee_chip_rom.sv | 14 +
 rtl/zigbee_chip_spreader.sv | 155 +++++++++++++++
 tb/tb_zigbee_chip_spreader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/zigbee_pkg.sv
// Shared types and constants for the 802.15.4 O-QPSK chip spreader.
// The PN table stores each sequence with chip c0 in bit 31 (MSB-first, as written).
package zigbee_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        CAPT   = 2'd2,
        SPREAD = 2'd3
    } state_e;

    localparam int CHIPS_PER_SYM  = 32;
    localparam int CHIPS_PER_BYTE = 64;

    // Symbols 1..7 are 4-chip right rotations of symbol 0; 8..15 invert the odd chips of 0..7.
    localparam logic [31:0] PN_TABLE [0:15] = '{
        32'hD9C3522E, 32'hED9C3522, 32'h2ED9C352, 32'h22ED9C35,
        32'h522ED9C3, 32'h3522ED9C, 32'hC3522ED9, 32'h9C3522ED,
        32'h8C96077B, 32'hB8C96077, 32'h7B8C9607, 32'h77B8C960,
        32'h077B8C96, 32'h6077B8C9, 32'h96077B8C, 32'hC96077B8
    };

    function automatic logic seq_chip(input logic [31:0] seq, input logic [4:0] idx);
        return seq[5'd31 - idx];
    endfunction

endpackage

// File: rtl/zigbee_chip_rom.sv
// Combinational nibble-to-PN-sequence lookup.
module zigbee_chip_rom
    import zigbee_pkg::*;
(
    input  logic [3:0]  nibble_i,
    output logic [31:0] seq_o
);

    // Table lookup of the 32-chip sequence for the current symbol
    always_comb begin
        seq_o = PN_TABLE[nibble_i];
    end

endmodule

// File: rtl/zigbee_chip_spreader.sv
// Byte-to-chip spreader: FIFO fetch, nibble split, PN mapping, I/Q chip output.
// Optional feature: define UNDERRUN_FLAG_EN to add the sticky underrun output.
module zigbee_chip_spreader
    import zigbee_pkg::*;
#(
    parameter bit LSB_NIBBLE_FIRST = 1'b1
) (
    input  logic       PCLK,
    input  logic       reset,
    input  logic       tx_enable,
    input  logic       chip_tick,
    input  logic       fifo_empty,
    input  logic [7:0] byte_in,
`ifdef UNDERRUN_FLAG_EN
    output logic       underrun,
`endif
    output logic       rd_req,
    output logic       chip_i,
    output logic       chip_q,
    output logic       tx_active
);

    localparam logic [5:0] LAST_IDX     = 6'(CHIPS_PER_BYTE - 1);
    localparam logic [5:0] PREFETCH_IDX = 6'(CHIPS_PER_BYTE - CHIPS_PER_SYM / 2 - 1);

    state_e     state_q;
    logic [5:0] chip_idx_q;
    logic [7:0] shift_q;
    logic [7:0] hold_q;
    logic       hold_valid_q;
    logic       cap_pend_q;
    logic       rd_req_q;
    logic       chip_i_q;
    logic       chip_q_q;
    logic       tx_active_q;
`ifdef UNDERRUN_FLAG_EN
    logic       underrun_q;
`endif

    logic [3:0]  cur_nib_d;
    logic [31:0] cur_seq_d;
    logic        cur_chip_d;
    logic        last_chip_d;
    logic        fetch_ok_d;

    zigbee_chip_rom u_rom (
        .nibble_i (cur_nib_d),
        .seq_o    (cur_seq_d)
    );

    // Current symbol selection and chip/prefetch qualifiers
    always_comb begin
        cur_nib_d   = shift_q[3:0];
        cur_chip_d  = 1'b0;
        last_chip_d = 1'b0;
        fetch_ok_d  = 1'b0;
        if (chip_idx_q[5] == LSB_NIBBLE_FIRST) begin
            cur_nib_d = shift_q[7:4];
        end else begin
            cur_nib_d = shift_q[3:0];
        end
        cur_chip_d  = seq_chip(cur_seq_d, chip_idx_q[4:0]);
        last_chip_d = (chip_idx_q == LAST_IDX);
        // Only one request may be in flight and the hold slot must be free.
        fetch_ok_d  = tx_enable && !fifo_empty && !hold_valid_q && !cap_pend_q && !rd_req_q;
    end

    // Control FSM, chip counter, byte registers and registered outputs
    always_ff @(posedge PCLK or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            chip_idx_q   <= 6'd0;
            shift_q      <= 8'd0;
            hold_q       <= 8'd0;
            hold_valid_q <= 1'b0;
            cap_pend_q   <= 1'b0;
            rd_req_q     <= 1'b0;
            chip_i_q     <= 1'b0;
            chip_q_q     <= 1'b0;
            tx_active_q  <= 1'b0;
`ifdef UNDERRUN_FLAG_EN
            underrun_q   <= 1'b0;
`endif
        end else begin
            rd_req_q   <= 1'b0;
            cap_pend_q <= rd_req_q && (state_q == SPREAD);
            // Prefetched byte is valid on byte_in one cycle after its request.
            if (cap_pend_q) begin
                hold_q       <= byte_in;
                hold_valid_q <= 1'b1;
            end
`ifdef UNDERRUN_FLAG_EN
            if (!tx_enable) begin
                underrun_q <= 1'b0;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (tx_enable && !fifo_empty) begin
                        rd_req_q <= 1'b1;
                        state_q  <= REQ;
                    end
                end
                REQ: begin
                    tx_active_q <= 1'b1;
                    state_q     <= CAPT;
                end
                CAPT: begin
                    shift_q    <= byte_in;
                    chip_idx_q <= 6'd0;
                    state_q    <= SPREAD;
                end
                SPREAD: begin
                    if (chip_tick) begin
                        if (!chip_idx_q[0]) begin
                            chip_i_q <= cur_chip_d;
                        end else begin
                            chip_q_q <= cur_chip_d;
                        end
                        chip_idx_q <= chip_idx_q + 6'd1;
                        if ((chip_idx_q == PREFETCH_IDX) && fetch_ok_d) begin
                            rd_req_q <= 1'b1;
                        end
                        if (last_chip_d) begin
                            if (hold_valid_q) begin
                                shift_q      <= hold_q;
                                hold_valid_q <= 1'b0;
                            end else begin
                                state_q     <= IDLE;
                                tx_active_q <= 1'b0;
`ifdef UNDERRUN_FLAG_EN
                                if (tx_enable && fifo_empty) begin
                                    underrun_q <= 1'b1;
                                end
`endif
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rd_req    = rd_req_q;
    assign chip_i    = chip_i_q;
    assign chip_q    = chip_q_q;
    assign tx_active = tx_active_q;
`ifdef UNDERRUN_FLAG_EN
    assign underrun  = underrun_q;
`endif

endmodule

// File: tb/tb_zigbee_chip_spreader.sv
// Self-checking bench for zigbee_chip_spreader: FIFO model, chip scoreboard, vector table.
module tb_zigbee_chip_spreader;

    typedef struct {
        logic [7:0] data;
        int         sa;
        int         sb;
    } vec_t;

    typedef struct {
        bit is_q;
        bit v;
    } chip_t;

    logic       PCLK = 1'b0;
    logic       reset;
    logic       tx_enable;
    logic       chip_tick;
    logic       fifo_empty;
    logic [7:0] byte_in;
    logic       rd_req;
    logic       chip_i;
    logic       chip_q;
    logic       tx_active;
`ifdef UNDERRUN_FLAG_EN
    logic       underrun;
`endif

    vec_t  fifo[$];
    chip_t expq[$];
    vec_t  table_v[6];

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    int guard = 0;
    int cons = 0;
    int n_rd = 0;
    int rd_base;
    bit exp_i = 1'b0;
    bit exp_q = 1'b0;

    zigbee_chip_spreader dut (
        .PCLK       (PCLK),
        .reset      (reset),
        .tx_enable  (tx_enable),
        .chip_tick  (chip_tick),
        .fifo_empty (fifo_empty),
        .byte_in    (byte_in),
`ifdef UNDERRUN_FLAG_EN
        .underrun   (underrun),
`endif
        .rd_req     (rd_req),
        .chip_i     (chip_i),
        .chip_q     (chip_q),
        .tx_active  (tx_active)
    );

    always #5 PCLK = ~PCLK;

    // Chip j of symbol sym, derived from symbol 0 by rotation and odd-chip inversion.
    function automatic bit pn_chip(input int sym, input int j);
        logic [31:0] s0;
        int          src;
        bit          c;
        s0  = 32'hD9C3522E;
        src = (j + 32 - 4 * (sym % 8)) % 32;
        c   = s0[31 - src];
        if (sym >= 8 && (j % 2) == 1) c = !c;
        return c;
    endfunction

    function automatic vec_t mk(input logic [7:0] d);
        vec_t r;
        r.data = d;
        r.sa   = int'(d[3:0]);
        r.sb   = int'(d[7:4]);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_byte(input vec_t v);
        fifo.push_back(v);
        fifo_empty = 1'b0;
    endtask

    task automatic cycle();
        bit    pre_rd;
        bit    tick;
        vec_t  v;
        chip_t c;
        tick      = ((cyc % 4) == 0);
        chip_tick = tick;
        pre_rd    = rd_req;
        if (pre_rd) begin
            n_rd++;
            check("rd_req_when_empty", {31'd0, fifo_empty}, 32'd0);
            if (expq.size() != 0) check("prefetch_idx", cons % 64, 32'd48);
        end
        @(posedge PCLK);
        #1;
        cyc++;
        if (tick && expq.size() != 0 && cyc > guard) begin
            c = expq.pop_front();
            if (c.is_q) exp_q = c.v;
            else        exp_i = c.v;
            cons++;
        end
        if (pre_rd && fifo.size() != 0) begin
            v       = fifo.pop_front();
            byte_in = v.data;
            fifo_empty = (fifo.size() == 0);
            if (expq.size() == 0) begin
                guard = cyc + 1;
                cons  = 0;
            end
            for (int j = 0; j < 64; j++) begin
                c.is_q = ((j % 2) == 1);
                c.v    = pn_chip((j < 32) ? v.sa : v.sb, j % 32);
                expq.push_back(c);
            end
        end
        check("outputs", {29'd0, tx_active, chip_i, chip_q},
              {29'd0, (expq.size() != 0), exp_i, exp_q});
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic wait_start(input int maxc);
        int k;
        k = 0;
        while (expq.size() == 0 && k < maxc) begin cycle(); k++; end
        if (expq.size() == 0) check("start_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_chips(input int n, input int maxc);
        int k;
        k = 0;
        while (cons < n && k < maxc) begin cycle(); k++; end
        if (cons < n) check("chip_timeout", cons, n);
    endtask

    task automatic wait_empty(input int maxc);
        int k;
        k = 0;
        while (expq.size() != 0 && k < maxc) begin cycle(); k++; end
        if (expq.size() != 0) check("frame_timeout", expq.size(), 32'd0);
    endtask

    initial begin
        table_v[0] = '{8'h00, 0, 0};
        table_v[1] = '{8'hA5, 5, 10};
        table_v[2] = '{8'h3C, 12, 3};
        table_v[3] = '{8'hF1, 1, 15};
        table_v[4] = '{8'h7E, 14, 7};
        table_v[5] = '{8'h96, 6, 9};

        reset = 1'b0; tx_enable = 1'b0; chip_tick = 1'b0; fifo_empty = 1'b1; byte_in = 8'h00;
        #23;
        check("reset_state", {28'd0, rd_req, chip_i, chip_q, tx_active}, 32'd0);
        reset = 1'b1;
        #1;

        // Empty FIFO with tx_enable: never a request, outputs stay 0
        tx_enable = 1'b1;
        rd_base = n_rd;
        run_cycles(100);
        check("empty_no_rd", n_rd - rd_base, 32'd0);

        // One byte per frame from the vector table
        for (int i = 0; i < 6; i++) begin
            rd_base = n_rd;
            push_byte(table_v[i]);
            tx_enable = 1'b1;
            wait_start(20);
            wait_empty(400);
            run_cycles(3);
            check("single_rd_count", n_rd - rd_base, 32'd1);
`ifdef UNDERRUN_FLAG_EN
            check("underrun_set", {31'd0, underrun}, 32'd1);
            tx_enable = 1'b0;
            cycle();
            check("underrun_clr", {31'd0, underrun}, 32'd0);
`endif
        end

        // Three bytes queued: gap-free, prefetch at chip 48 of each byte
        rd_base = n_rd;
        push_byte(mk(8'h12)); push_byte(mk(8'h9B)); push_byte(mk(8'hE7));
        tx_enable = 1'b1;
        wait_start(20);
        wait_empty(1000);
        run_cycles(3);
        check("three_rd_count", n_rd - rd_base, 32'd3);

        // tx_enable dropped at chip 10: byte completes, no further reads
        rd_base = n_rd;
        push_byte(mk(8'h4D)); push_byte(mk(8'h80));
        tx_enable = 1'b1;
        wait_start(20);
        wait_chips(10, 100);
        tx_enable = 1'b0;
        wait_empty(400);
        run_cycles(20);
        check("drop_rd_count", n_rd - rd_base, 32'd1);
        check("drop_fifo_left", fifo.size(), 32'd1);
`ifdef UNDERRUN_FLAG_EN
        check("drop_underrun", {31'd0, underrun}, 32'd0);
`endif
        fifo.delete();
        fifo_empty = 1'b1;

        // Reset at chip 40, then a fresh fetch re-emits chip 0
        push_byte(mk(8'hC3)); push_byte(mk(8'h5A));
        tx_enable = 1'b1;
        wait_start(20);
        wait_chips(40, 300);
        chip_tick = 1'b0;
        reset = 1'b0;
        #1;
        check("reset_async", {28'd0, rd_req, chip_i, chip_q, tx_active}, 32'd0);
`ifdef UNDERRUN_FLAG_EN
        check("reset_underrun", {31'd0, underrun}, 32'd0);
`endif
        expq.delete();
        exp_i = 1'b0; exp_q = 1'b0;
        #3;
        reset = 1'b1;
        rd_base = n_rd;
        wait_start(20);
        wait_empty(400);
        run_cycles(3);
        check("after_reset_rd", n_rd - rd_base, 32'd1);
        check("after_reset_fifo", fifo.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
